// File: rtl/sig_dump_pkg.sv
// Shared types and constants for the signature dump controller:
// FSM state encoding, default mailbox addresses and DRAM base address.
package sig_dump_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_WAIT = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } sig_state_t;

   localparam logic [31:0] SIG_BEGIN_ADDR = 32'h0000_0508;
   localparam logic [31:0] SIG_END_ADDR   = 32'h0000_050C;
   localparam logic [31:0] SIG_HALT_ADDR  = 32'h0000_0600;
   localparam logic [31:0] SIG_DRAM_BASE  = 32'h4000_0000;

   function automatic logic [31:0] byte_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
      return addr - base;
   endfunction

   // Compared at 33 bits so a pointer near the top of memory cannot wrap.
   function automatic logic is_last_word(input logic [31:0] ptr,
                                         input logic [31:0] sig_end);
      return ({1'b0, ptr} + 33'd4) >= {1'b0, sig_end};
   endfunction

endpackage

// File: rtl/sig_dump_ctrl.sv
// Snoops the core's DRAM write bus for signature mailbox writes and, on halt,
// streams the signature region out word by word over valid/ready.
module sig_dump_ctrl
   import sig_dump_pkg::*;
#(
   parameter logic [31:0] BEGIN_ADDR = SIG_BEGIN_ADDR,
   parameter logic [31:0] END_ADDR   = SIG_END_ADDR,
   parameter logic [31:0] HALT_ADDR  = SIG_HALT_ADDR,
   parameter logic [31:0] DRAM_BASE  = SIG_DRAM_BASE,
   parameter int          AW         = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dram_we,
   input  logic [31:0]   dram_addr,
   input  logic [31:0]   dram_wdat,
   output logic          rd_en,
   output logic [AW-1:0] rd_idx,
   input  logic [31:0]   rd_dat,
   output logic          out_valid,
   output logic [31:0]   out_data,
   output logic          out_last,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
);

   sig_state_t    state_q, state_d;
   logic [31:0]   sig_begin_q, sig_begin_d;
   logic [31:0]   sig_end_q, sig_end_d;
   logic [31:0]   ptr_q, ptr_d;
   logic [31:0]   out_data_q, out_data_d;
   logic          out_last_q, out_last_d;
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] rd_idx_q, rd_idx_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Next-state, mailbox capture and datapath update.
   always_comb begin
      state_d     = state_q;
      sig_begin_d = sig_begin_q;
      sig_end_d   = sig_end_q;
      ptr_d       = ptr_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      case (state_q)
         ST_IDLE: begin
            if (dram_we) begin
               if (dram_addr == BEGIN_ADDR) begin
                  sig_begin_d = dram_wdat;
               end else if (dram_addr == END_ADDR) begin
                  sig_end_d = dram_wdat;
               end else if (dram_addr == HALT_ADDR) begin
                  ptr_d = sig_begin_q;
                  if (sig_begin_q >= sig_end_q) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_READ;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            out_data_d = rd_dat;
            out_last_d = is_last_word(ptr_q, sig_end_q);
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (out_ready) begin
               ptr_d = ptr_q + 32'd4;
               if (out_last_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output flags are decoded from the next state so they leave a flop.
   always_comb begin
      rd_en_d     = (state_d == ST_READ);
      rd_idx_d    = AW'(byte_offset(ptr_d, DRAM_BASE) >> 2);
      out_valid_d = (state_d == ST_SEND);
      busy_d      = (state_d == ST_READ) || (state_d == ST_WAIT) || (state_d == ST_SEND);
      done_d      = (state_d == ST_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sig_begin_q <= 32'd0;
         sig_end_q   <= 32'd0;
         ptr_q       <= 32'd0;
         out_data_q  <= 32'd0;
         out_last_q  <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_idx_q    <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sig_begin_q <= sig_begin_d;
         sig_end_q   <= sig_end_d;
         ptr_q       <= ptr_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         rd_en_q     <= rd_en_d;
         rd_idx_q    <= rd_idx_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rd_en     = rd_en_q;
   assign rd_idx    = rd_idx_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Scoreboard bench for sig_dump_ctrl: a DRAM model answers reads, expected
// words are queued when a dump is triggered and popped on each handshake.
module tb_sig_dump_ctrl;
   import sig_dump_pkg::*;

   logic        clk;
   logic        rst;
   logic        dram_we;
   logic [31:0] dram_addr;
   logic [31:0] dram_wdat;
   logic        rd_en;
   logic [11:0] rd_idx;
   logic [31:0] rd_dat;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_ready;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:4095];
   logic [31:0] exp_data_q[$];
   logic        exp_last_q[$];
   logic [11:0] exp_idx_q[$];

   sig_dump_ctrl dut (
      .clk(clk), .rst(rst), .dram_we(dram_we), .dram_addr(dram_addr),
      .dram_wdat(dram_wdat), .rd_en(rd_en), .rd_idx(rd_idx), .rd_dat(rd_dat),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DRAM read port: data valid the cycle after rd_en, junk otherwise.
   always @(posedge clk) begin
      if (rd_en) rd_dat <= mem[rd_idx];
      else       rd_dat <= 32'hDEAD_BEEF;
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; dram_we = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic mbox_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      dram_we = 1'b1; dram_addr = addr; dram_wdat = data;
      @(negedge clk);
      dram_we = 1'b0;
   endtask

   // Triggers a dump and follows it; returns at a negedge after the last
   // handshake (or right after the abort reset cycle).
   task automatic run_dump(input logic [31:0] b, input logic [31:0] e,
                           input int stall_k, input int stall_n,
                           input bit inject_end, input bit abort, input string tag,
                           output int words);
      int n, rds, c, first_c, stalls;
      bit fin, injected, prev_rd, aborted;
      logic [11:0] idx;
      exp_data_q.delete(); exp_last_q.delete(); exp_idx_q.delete();
      n = (e > b) ? int'((e - b + 32'd3) >> 2) : 0;
      for (int k = 0; k < n; k++) begin
         idx = 12'(((b - SIG_DRAM_BASE) >> 2) + 32'(k));
         exp_idx_q.push_back(idx);
         exp_data_q.push_back(mem[idx]);
         exp_last_q.push_back(k == n - 1);
      end
      words = 0; rds = 0; stalls = 0; first_c = -1;
      fin = 1'b0; injected = 1'b0; prev_rd = 1'b0; aborted = 1'b0;
      mbox_write(SIG_BEGIN_ADDR, b);
      mbox_write(SIG_END_ADDR, e);
      mbox_write(SIG_HALT_ADDR, 32'd0);
      // now in cycle T+1
      checks++;
      if (n == 0) begin
         if (done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_t1_empty: done=%b busy=%b rd_en=%b, want 1 0 0", tag, done, busy, rd_en);
         end
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (rd_en !== 1'b0 || out_valid !== 1'b0 || done !== 1'b1) begin
               errors++;
               $display("FAIL %s_quiet: rd_en=%b out_valid=%b done=%b, want 0 0 1", tag, rd_en, out_valid, done);
            end
         end
         return;
      end
      if (busy !== 1'b1 || rd_en !== 1'b1) begin
         errors++;
         $display("FAIL %s_t1: busy=%b rd_en=%b, want 1 1", tag, busy, rd_en);
      end
      c = 1;
      while (!fin && !aborted && c < 300) begin
         if (rd_en) begin
            rds++;
            checks++;
            if (exp_idx_q.size() == 0) begin
               errors++;
               $display("FAIL %s_extra_rd: rd_idx=%0d, want no read", tag, rd_idx);
            end else begin
               idx = exp_idx_q.pop_front();
               if (rd_idx !== idx || out_valid !== 1'b0 || prev_rd) begin
                  errors++;
                  $display("FAIL %s_rd: idx=%0d valid=%b prev_rd=%b, want idx=%0d valid=0 prev_rd=0",
                           tag, rd_idx, out_valid, prev_rd, idx);
               end
            end
         end
         prev_rd = rd_en;
         if (out_valid) begin
            if (first_c < 0) begin
               first_c = c;
               checks++;
               if (first_c != 3) begin
                  errors++;
                  $display("FAIL %s_first_valid: cycle T+%0d, want T+3", tag, first_c);
               end
            end
            checks++;
            if (exp_data_q.size() == 0) begin
               errors++;
               $display("FAIL %s_extra_word: data=%h, want none", tag, out_data);
               fin = 1'b1;
            end else if (out_data !== exp_data_q[0] || out_last !== exp_last_q[0]) begin
               errors++;
               $display("FAIL %s_word%0d: data=%h last=%b, want %h %b",
                        tag, words, out_data, out_last, exp_data_q[0], exp_last_q[0]);
            end
            if (abort && words == 1) begin
               rst = 1'b1; out_ready = 1'b0; aborted = 1'b1;
            end else if (inject_end && !injected) begin
               dram_we = 1'b1; dram_addr = SIG_END_ADDR; dram_wdat = 32'h4000_1000;
               out_ready = 1'b0; injected = 1'b1;
            end else if (words == stall_k && stalls < stall_n) begin
               out_ready = 1'b0; stalls++;
            end else begin
               out_ready = 1'b1;
               if (exp_data_q.size() != 0) begin
                  void'(exp_data_q.pop_front());
                  fin = exp_last_q.pop_front();
                  words++;
               end
            end
         end else begin
            out_ready = 1'b1;
         end
         @(negedge clk);
         dram_we = 1'b0;
         c++;
      end
      out_ready = 1'b0;
      if (aborted) begin
         rst = 1'b0;
         return;
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL %s_timeout: words=%0d, want %0d", tag, words, n);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_end: done=%b busy=%b valid=%b, want 1 0 0", tag, done, busy, out_valid);
      end
      checks++;
      if (words != n || rds != n) begin
         errors++;
         $display("FAIL %s_count: words=%0d reads=%0d, want %0d", tag, words, rds, n);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (rd_en !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || out_data !== 32'd0) begin
         errors++;
         $display("FAIL reset: rd_en=%b valid=%b last=%b busy=%b done=%b data=%h, want all 0",
                  rd_en, out_valid, out_last, busy, done, out_data);
      end
   endtask

   task automatic test_basic();
      int w;
      apply_reset();
      run_dump(32'h4000_0010, 32'h4000_0020, -1, 0, 1'b0, 1'b0, "basic", w);
   endtask

   task automatic test_stall();
      int w;
      apply_reset();
      run_dump(32'h4000_0010, 32'h4000_0020, 1, 5, 1'b0, 1'b0, "stall", w);
   endtask

   task automatic test_empty();
      int w;
      apply_reset();
      run_dump(32'h4000_0040, 32'h4000_0040, -1, 0, 1'b0, 1'b0, "empty", w);
   endtask

   task automatic test_partial();
      int w;
      apply_reset();
      run_dump(32'h4000_0000, 32'h4000_0006, -1, 0, 1'b0, 1'b0, "partial", w);
   endtask

   task automatic test_frozen_mailbox();
      int w;
      apply_reset();
      run_dump(32'h4000_0010, 32'h4000_0020, -1, 0, 1'b1, 1'b0, "frozen", w);
      mbox_write(SIG_HALT_ADDR, 32'd0);
      for (int i = 0; i < 15; i++) begin
         checks++;
         if (done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL frozen_rehalt: done=%b busy=%b rd_en=%b valid=%b, want 1 0 0 0",
                     done, busy, rd_en, out_valid);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_send();
      int w;
      apply_reset();
      run_dump(32'h4000_0010, 32'h4000_0020, -1, 0, 1'b0, 1'b1, "abort", w);
      checks++;
      if (rd_en !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || out_data !== 32'd0) begin
         errors++;
         $display("FAIL abort_reset: rd_en=%b valid=%b last=%b busy=%b done=%b data=%h, want all 0",
                  rd_en, out_valid, out_last, busy, done, out_data);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (rd_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: rd_en=%b valid=%b busy=%b, want 0 0 0", rd_en, out_valid, busy);
         end
      end
      run_dump(32'h4000_0100, 32'h4000_010C, -1, 0, 1'b0, 1'b0, "fresh", w);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0011;
      rst = 1'b0; dram_we = 1'b0; dram_addr = 32'd0; dram_wdat = 32'd0; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_empty();
      test_partial();
      test_frozen_mailbox();
      test_reset_mid_send();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
